mips_cpu_muldiv: RTL and testbench

Parametrised multiply/divide unit with integrated HI/LO architectural registers. It is the successor to the plain HI/LO register pair. It keeps direct HI/LO write ports (MTHI/MTLO), adds iterative signed/unsigned multiply and divide with a busy handshake for pipeline stall, and optionally adds multiply-accumulate. It sits beside the ALU in the execute stage; MFHI/MFLO read `read_hi`/`read_lo` combinationally from the registers.

---
 rtl/mips_cpu_muldiv_pkg.sv | 49 ++++
 rtl/mips_cpu_muldiv_divider.sv | 50 +++++
 rtl/mips_cpu_muldiv.sv | 172 +++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and op-decode helpers for the multiply/divide unit.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic is_signed_op(input muldiv_op_t op);
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: is_signed_op = 1'b1;
      default:                           is_signed_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    case (op)
      OP_DIV, OP_DIVU: is_div_op = 1'b1;
      default:         is_div_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_acc_op(input muldiv_op_t op);
    case (op)
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_acc_op = 1'b1;
      default:                              is_acc_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_sub_op(input muldiv_op_t op);
    case (op)
      OP_MSUB, OP_MSUBU: is_sub_op = 1'b1;
      default:           is_sub_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per enabled step.
module mips_cpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   trial_s;

  // Partial remainder with the next dividend bit shifted in, minus the divisor.
  assign trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};

  // Load operands, then shift one quotient bit in per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (load) begin
      rem_r <= '0;
      quo_r <= dividend;
      dvs_r <= divisor;
    end else if (step_en) begin
      if (!trial_s[WIDTH]) begin
        rem_r <= trial_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multiply/divide unit with HI/LO registers; WIDTH-step iterative datapath with busy stall.
// Define MIPS_CPU_MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (op codes 4-7).
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] data_hi,
  input  logic [WIDTH-1:0] data_lo,
  input  logic             hi_en,
  input  logic             lo_en,
  output logic             busy,
  output logic [WIDTH-1:0] read_hi,
  output logic [WIDTH-1:0] read_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  muldiv_state_t      state_r;
  muldiv_op_t         op_s, op_r;
  logic [CW-1:0]      count_r;
  logic               busy_r, div_by_zero_r, dz_r, neg_lo_r, neg_hi_r;
  logic [WIDTH-1:0]   hi_r, lo_r, a_raw_r, mcand_r;
  logic [2*WIDTH-1:0] prod_r, prod_step_s, prod_signed_s, mul_res_s;
  logic [WIDTH:0]     add_s;
  logic               op_ok_s, start_ok_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quo_s, rem_s, quo_fix_s, rem_fix_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;
`ifdef MIPS_CPU_MULDIV_MADD_EN
  logic [2*WIDTH-1:0] acc_r;
`endif

  assign op_s = muldiv_op_t'(op);

  // Decode which op codes this build executes.
  always_comb begin
    op_ok_s = 1'b0;
    case (op_s)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_ok_s = 1'b1;
`ifdef MIPS_CPU_MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_ok_s = 1'b1;
`endif
      default: op_ok_s = 1'b0;
    endcase
  end

  assign start_ok_s = (state_r == IDLE) && start && op_ok_s;
  assign a_neg_s    = is_signed_op(op_s) & a[WIDTH-1];
  assign b_neg_s    = is_signed_op(op_s) & b[WIDTH-1];
  assign a_mag_s    = a_neg_s ? (~a + ONE_W) : a;
  assign b_mag_s    = b_neg_s ? (~b + ONE_W) : b;

  // Shift-add step: add multiplicand into the upper half when the LSB is set, then shift right.
  assign add_s       = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, mcand_r} : '0);
  assign prod_step_s = {add_s, prod_r[WIDTH-1:1]};

  mips_cpu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok_s && is_div_op(op_s)),
    .step_en   ((state_r == RUN) && is_div_op(op_r)),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Sign correction and result selection for the FIX writeback.
  always_comb begin
    prod_signed_s = neg_lo_r ? (~prod_r + ONE_2W) : prod_r;
    mul_res_s     = prod_signed_s;
`ifdef MIPS_CPU_MULDIV_MADD_EN
    if (is_acc_op(op_r)) begin
      if (is_sub_op(op_r)) begin
        mul_res_s = acc_r - prod_signed_s;
      end else begin
        mul_res_s = acc_r + prod_signed_s;
      end
    end else begin
      mul_res_s = prod_signed_s;
    end
`endif
    quo_fix_s = neg_lo_r ? (~quo_s + ONE_W) : quo_s;
    rem_fix_s = neg_hi_r ? (~rem_s + ONE_W) : rem_s;
    if (!is_div_op(op_r)) begin
      fix_hi_s = mul_res_s[2*WIDTH-1:WIDTH];
      fix_lo_s = mul_res_s[WIDTH-1:0];
    end else if (dz_r) begin
      fix_hi_s = a_raw_r;
      fix_lo_s = '1;
    end else begin
      fix_hi_s = rem_fix_s;
      fix_lo_s = quo_fix_s;
    end
  end

  // Control FSM, HI/LO registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      count_r       <= '0;
      busy_r        <= 1'b0;
      div_by_zero_r <= 1'b0;
      dz_r          <= 1'b0;
      neg_lo_r      <= 1'b0;
      neg_hi_r      <= 1'b0;
      op_r          <= OP_MULT;
      hi_r          <= '0;
      lo_r          <= '0;
      a_raw_r       <= '0;
      mcand_r       <= '0;
      prod_r        <= '0;
`ifdef MIPS_CPU_MULDIV_MADD_EN
      acc_r         <= '0;
`endif
    end else begin
      div_by_zero_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hi_en) hi_r <= data_hi;
          if (lo_en) lo_r <= data_lo;
          if (start_ok_s) begin
            state_r  <= RUN;
            count_r  <= CW'(WIDTH-1);
            busy_r   <= 1'b1;
            op_r     <= op_s;
            neg_lo_r <= a_neg_s ^ b_neg_s;
            neg_hi_r <= a_neg_s;
            dz_r     <= is_div_op(op_s) && (b == '0);
            a_raw_r  <= a;
            mcand_r  <= a_mag_s;
            prod_r   <= {{WIDTH{1'b0}}, b_mag_s};
`ifdef MIPS_CPU_MULDIV_MADD_EN
            acc_r    <= {hi_r, lo_r};
`endif
          end
        end
        RUN: begin
          prod_r <= prod_step_s;
          if (count_r == '0) begin
            state_r <= FIX;
          end else begin
            count_r <= count_r - CW'(1);
          end
        end
        FIX: begin
          hi_r          <= fix_hi_s;
          lo_r          <= fix_lo_s;
          busy_r        <= 1'b0;
          div_by_zero_r <= dz_r;
          state_r       <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy        = busy_r;
  assign read_hi     = hi_r;
  assign read_lo     = lo_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: vector table plus hand-written corner sequences.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_en, lo_en;
  logic [2:0]   op;
  logic [W-1:0] a, b, data_hi, data_lo;
  logic         busy, div_by_zero;
  logic [W-1:0] read_hi, read_lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    logic         exp_dz;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   n_vec = 0, n_cmp = 0, n_err = 0, busy_cnt = 0;

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .data_hi(data_hi), .data_lo(data_lo), .hi_en(hi_en), .lo_en(lo_en),
    .busy(busy), .read_hi(read_hi), .read_lo(read_lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic dwrite(input logic [W-1:0] h, input logic [W-1:0] l);
    hi_en = 1'b1; lo_en = 1'b1; data_hi = h; data_lo = l;
    @(negedge clk);
    hi_en = 1'b0; lo_en = 1'b0;
  endtask

  // Drive start at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input logic wr, input logic [W-1:0] wval);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    sb_q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    hi_en = wr; data_hi = wval;
    @(negedge clk);
    start = 1'b0; hi_en = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    if (wr) chk("write_with_start", read_hi, wval);
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic finish_op();
    exp_t e;
    int guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) busy_cnt++;
    end
    if (guard >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, want %0d", guard, W+1);
    end
    e = sb_q.pop_front();
    chk("busy_cycles", busy_cnt, W+1);
    chk("result_hi", read_hi, e.hi);
    chk("result_lo", read_lo, e.lo);
    chk("div_by_zero_pulse", div_by_zero, e.dz);
    @(negedge clk);
    chk("div_by_zero_clear", div_by_zero, 1'b0);
    chk("busy_stays_low", busy, 1'b0);
    n_vec++;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'd0,  32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'd0,  32'd0,  32'd7,        32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,  32'd0,  32'd0,        32'h80000000, 1'b0};
    vecs[5]  = '{3'd0, 32'h80000000, 32'h80000000, 32'd0,  32'd0,  32'h40000000, 32'd0,        1'b0};
    vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd0,  32'd0,  32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd0,  32'd0,  32'hFFFFFFFE, 32'd2,        1'b0};
    vecs[8]  = '{3'd1, 32'h12345678, 32'h10,       32'd0,  32'd0,  32'd1,        32'h23456780, 1'b0};
    vecs[9]  = '{3'd2, 32'hFFFFFFFB, 32'd0,        32'd0,  32'd0,  32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'd0, 32'd7,        32'hFFFFFFFF, 32'd55, 32'd66, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'd16,       32'd0,  32'd0,  32'h0000000F, 32'h0FFFFFFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    data_hi = '0; data_lo = '0; hi_en = 1'b0; lo_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_hi", read_hi, 32'd0);
    chk("reset_lo", read_lo, 32'd0);
    chk("reset_dz", div_by_zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Direct write lands one edge after the enable.
    dwrite(32'd100, 32'd200);
    chk("direct_hi", read_hi, 32'd100);
    chk("direct_lo", read_lo, 32'd200);
    n_vec++;

    // Direct write and a second start while busy are both ignored.
    issue(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 32'd0);
    hi_en = 1'b1; lo_en = 1'b1; data_hi = 32'd5; data_lo = 32'd5;
    start = 1'b1; op = 3'd3; a = 32'd1; b = 32'd1;
    @(negedge clk);
    if (busy === 1'b1) busy_cnt++;
    hi_en = 1'b0; lo_en = 1'b0; start = 1'b0;
    chk("busy_write_hi", read_hi, 32'd100);
    chk("busy_write_lo", read_lo, 32'd200);
    finish_op();

    for (int i = 0; i < 12; i++) begin
      dwrite(vecs[i].pre_hi, vecs[i].pre_lo);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
            vecs[i].exp_dz, 1'b0, 32'd0);
      finish_op();
    end

    // Direct write coinciding with start is later overwritten by the result.
    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, 32'd77);
    finish_op();

    // Reset in the middle of RUN aborts without writing a result.
    dwrite(32'd9, 32'd9);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", read_hi, 32'd0);
    chk("abort_lo", read_lo, 32'd0);
    issue(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 32'd0);
    finish_op();

`ifdef MIPS_CPU_MULDIV_MADD_EN
    dwrite(32'd0, 32'd5);
    issue(OP_MADD, 32'd2, 32'd3, 32'd0, 32'd11, 1'b0, 1'b0, 32'd0);
    finish_op();
    issue(OP_MSUBU, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0, 32'd0);
    finish_op();
    dwrite(32'd0, 32'd10);
    issue(OP_MADD, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd4, 1'b0, 1'b0, 32'd0);
    finish_op();
`else
    dwrite(32'h11, 32'h22);
    start = 1'b1; op = 3'd4; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("undef_op_busy", busy, 1'b0);
    chk("undef_op_hi", read_hi, 32'h11);
    chk("undef_op_lo", read_lo, 32'h22);
    @(negedge clk);
    chk("undef_op_busy_later", busy, 1'b0);
    n_vec++;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
